// File: rtl/stage_waveform_generator_pkg.sv
`default_nettype none
// ============================================================================
// stage_waveform_generator_pkg : shared sizes, types and feedback helper
// Rev 1.0
// ============================================================================
package stage_waveform_generator_pkg;

  localparam int NUM_VOICE_OPERATORS = 8;
  localparam int VOICE_OPERATOR_ID   = 3;
  localparam int WAVEFORM_TABLE_BITS = 10;
  localparam int FEEDBACK_LEVEL_BITS = 3;

  typedef logic signed [15:0]              sample_t;
  typedef logic [VOICE_OPERATOR_ID-1:0]    op_id_t;
  typedef logic [FEEDBACK_LEVEL_BITS-1:0]  fb_level_t;

  // Levels 1..7 map to arithmetic shifts 7..1; level 0 or stale history gives 0.
  function automatic sample_t feedback_term(input sample_t last, input fb_level_t level,
                                            input logic valid);
    if (!valid || level == '0) return '0;
    return last >>> (4'd8 - {1'b0, level});
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_waveform_generator_sine_quarter_table.sv
`default_nettype none
// ============================================================================
// sine_quarter_table : 1024 x 15-bit quarter-wave sine ROM, 1-cycle read
// Rev 1.0
// ============================================================================
module sine_quarter_table
  import stage_waveform_generator_pkg::*;
(
  input  logic                           i_Clock,
  input  logic [WAVEFORM_TABLE_BITS-1:0] i_Addr,
  output logic [14:0]                    o_Data
);

  localparam int  c_DEPTH = 1 << WAVEFORM_TABLE_BITS;
  localparam real c_PI    = 3.14159265358979323846;

  logic [14:0] w_Table [c_DEPTH];
  logic [14:0] r_Data;

  // Half-step sample points make the quadrant mirror exact.
  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
    localparam real c_ANGLE = (real'(gi) + 0.5) * c_PI / real'(2 * c_DEPTH);
    localparam int  c_VALUE = $rtoi(32767.0 * $sin(c_ANGLE) + 0.5);
    assign w_Table[gi] = c_VALUE[14:0];
  end

  always_ff @(posedge i_Clock) begin
    r_Data <= w_Table[i_Addr];
  end

  assign o_Data = r_Data;

endmodule
`default_nettype wire

// File: rtl/stage_waveform_generator.sv
`default_nettype none
// ============================================================================
// stage_waveform_generator : phase + modulation + self-feedback -> sine sample
// Rev 1.0
// ============================================================================
module stage_waveform_generator
  import stage_waveform_generator_pkg::*;
(
  input  logic         i_Clock,
  input  logic         i_Reset_n,
  input  logic [15:0]  i_Phase,
  input  logic         i_NoteOn,
  input  op_id_t       i_VoiceOperator,
  input  logic [15:0]  i_ModulationPhase,
  input  logic         i_FeedbackConfigWriteEnable,
  input  op_id_t       i_ConfigWriteAddr,
  input  logic [15:0]  i_ConfigWriteData,
  output logic [15:0]  o_Waveform,
  output logic         o_NoteOn,
  output op_id_t       o_VoiceOperator
);

  fb_level_t                      r_FeedbackLevel [NUM_VOICE_OPERATORS];
  sample_t                        r_LastSample    [NUM_VOICE_OPERATORS];
  logic [NUM_VOICE_OPERATORS-1:0] r_LastValid;

  logic [WAVEFORM_TABLE_BITS-1:0] r_Index1;
  logic                           r_Neg1, r_NoteOn1;
  op_id_t                         r_Op1;
  logic                           r_Neg2, r_NoteOn2;
  op_id_t                         r_Op2;
  sample_t                        r_Waveform;
  logic                           r_NoteOn3;
  op_id_t                         r_Op3;

  sample_t                        w_Feedback;
  logic [15:0]                    w_Phase;
  logic [WAVEFORM_TABLE_BITS-1:0] w_Index;
  logic [14:0]                    w_RomData;
  sample_t                        w_Sample;
  logic                           w_unused_bits;

  assign w_Feedback = feedback_term(r_LastSample[i_VoiceOperator],
                                    r_FeedbackLevel[i_VoiceOperator],
                                    r_LastValid[i_VoiceOperator]);
  // Modulo-2^16 sum: wrap-around is the intended phase behaviour.
  assign w_Phase = i_Phase + i_ModulationPhase + w_Feedback;
  assign w_Index = w_Phase[14] ? ~w_Phase[13:4] : w_Phase[13:4];
  assign w_unused_bits = ^{i_ConfigWriteData[15:FEEDBACK_LEVEL_BITS], w_Phase[3:0]};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_VOICE_OPERATORS; i++) r_FeedbackLevel[i] <= '0;
    end else if (i_FeedbackConfigWriteEnable) begin
      r_FeedbackLevel[i_ConfigWriteAddr] <= i_ConfigWriteData[FEEDBACK_LEVEL_BITS-1:0];
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Index1  <= '0;
      r_Neg1    <= 1'b0;
      r_NoteOn1 <= 1'b0;
      r_Op1     <= '0;
      r_Neg2    <= 1'b0;
      r_NoteOn2 <= 1'b0;
      r_Op2     <= '0;
    end else begin
      r_Index1  <= w_Index;
      r_Neg1    <= w_Phase[15];
      r_NoteOn1 <= i_NoteOn;
      r_Op1     <= i_VoiceOperator;
      r_Neg2    <= r_Neg1;
      r_NoteOn2 <= r_NoteOn1;
      r_Op2     <= r_Op1;
    end
  end

  sine_quarter_table u_table (
    .i_Clock (i_Clock),
    .i_Addr  (r_Index1),
    .o_Data  (w_RomData)
  );

  always_comb begin
    w_Sample = '0;
    if (r_NoteOn2) begin
      w_Sample = r_Neg2 ? -$signed({1'b0, w_RomData}) : $signed({1'b0, w_RomData});
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Waveform  <= '0;
      r_NoteOn3   <= 1'b0;
      r_Op3       <= '0;
      r_LastValid <= '0;
    end else begin
      r_Waveform         <= w_Sample;
      r_NoteOn3          <= r_NoteOn2;
      r_Op3              <= r_Op2;
      r_LastValid[r_Op2] <= r_NoteOn2;
    end
  end

  // Sample history is RAM-like storage; validity alone gates its use.
  always_ff @(posedge i_Clock) begin
    r_LastSample[r_Op2] <= w_Sample;
  end

  assign o_Waveform      = r_Waveform;
  assign o_NoteOn        = r_NoteOn3;
  assign o_VoiceOperator = r_Op3;

endmodule
`default_nettype wire

// File: tb/tb_stage_waveform_generator.sv
`default_nettype none
// ============================================================================
// tb_stage_waveform_generator : directed + random check against a sine model
// Rev 1.0
// ============================================================================
module tb_stage_waveform_generator;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n;
  logic [15:0] i_Phase;
  logic        i_NoteOn;
  logic [2:0]  i_VoiceOperator;
  logic [15:0] i_ModulationPhase;
  logic        i_FeedbackConfigWriteEnable;
  logic [2:0]  i_ConfigWriteAddr;
  logic [15:0] i_ConfigWriteData;
  logic [15:0] o_Waveform;
  logic        o_NoteOn;
  logic [2:0]  o_VoiceOperator;

  stage_waveform_generator dut (
    .i_Clock                     (i_Clock),
    .i_Reset_n                   (i_Reset_n),
    .i_Phase                     (i_Phase),
    .i_NoteOn                    (i_NoteOn),
    .i_VoiceOperator             (i_VoiceOperator),
    .i_ModulationPhase           (i_ModulationPhase),
    .i_FeedbackConfigWriteEnable (i_FeedbackConfigWriteEnable),
    .i_ConfigWriteAddr           (i_ConfigWriteAddr),
    .i_ConfigWriteData           (i_ConfigWriteData),
    .o_Waveform                  (o_Waveform),
    .o_NoteOn                    (o_NoteOn),
    .o_VoiceOperator             (o_VoiceOperator)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    int    wave;
    bit    non;
    int    op;
    bit    has_lit;
    int    lit;
    string tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   m_level [8];
  int   m_last  [8];
  bit   m_valid [8];

  task automatic chk(input string tag, input int obs, input int want);
    n_checks++;
    if (obs != want) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int rom(input int idx);
    real a;
    a = (real'(idx) + 0.5) * 3.14159265358979323846 / 2048.0;
    return $rtoi(32767.0 * $sin(a) + 0.5);
  endfunction

  // Model: sine of (phase + mod + feedback) mod 2^16, via quarter-wave symmetry.
  task automatic drive(input logic [15:0] ph, input logic [15:0] mod, input bit non,
                       input bit we, input int waddr, input int wlev,
                       input bit has_lit, input int lit, input string tag);
    exp_t e;
    int op, f, p, quad, idx, s;
    op = cyc % 8;
    @(negedge i_Clock);
    i_Phase                     = ph;
    i_ModulationPhase           = mod;
    i_NoteOn                    = non;
    i_VoiceOperator             = 3'(op);
    i_FeedbackConfigWriteEnable = we;
    i_ConfigWriteAddr           = 3'(waddr);
    i_ConfigWriteData           = {13'($urandom), 3'(wlev)};
    f = 0;
    if (m_level[op] != 0 && m_valid[op]) f = m_last[op] >>> (8 - m_level[op]);
    p    = (int'(ph) + int'($signed(mod)) + f) & 32'hFFFF;
    quad = p >> 14;
    idx  = (p >> 4) & 1023;
    if ((quad & 1) != 0) idx = 1023 - idx;
    s = 0;
    if (non) s = (quad >= 2) ? -rom(idx) : rom(idx);
    m_last[op]  = s;
    m_valid[op] = non;
    if (we) m_level[waddr] = wlev;
    e = '{s, non, op, has_lit, lit, tag};
    q.push_back(e);
    cyc++;
    @(posedge i_Clock);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk({e.tag, "_wave"}, int'($signed(o_Waveform)), e.wave);
      chk({e.tag, "_noteon"}, int'(o_NoteOn), int'(e.non));
      chk({e.tag, "_op"}, int'(o_VoiceOperator), e.op);
      if (e.has_lit) chk({e.tag, "_lit"}, int'($signed(o_Waveform)), e.lit);
    end
  endtask

  task automatic idle();
    drive(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 0, 1'b0, 0, "idle");
  endtask

  // One full rotation of operators; only operator 2 carries the note.
  task automatic pass_op2(input logic [15:0] ph, input bit non, input bit we, input int wlev,
                          input bit has_lit, input int lit, input string tag);
    for (int k = 0; k < 8; k++) begin
      if (cyc % 8 == 2) drive(ph, 16'h0000, non, we, 2, wlev, has_lit, lit, tag);
      else idle();
    end
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk("rst_wave", int'($signed(o_Waveform)), 0);
    chk("rst_noteon", int'(o_NoteOn), 0);
    chk("rst_op", int'(o_VoiceOperator), 0);
    i_NoteOn = 1'b0;
    i_FeedbackConfigWriteEnable = 1'b0;
    repeat (2) @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      m_level[i] = 0;
      m_valid[i] = 1'b0;
      m_last[i]  = 0;
    end
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) begin
      drive(16'($urandom), ($urandom % 2 == 0) ? 16'($urandom) : 16'h0000,
            ($urandom % 5) != 0, ($urandom % 4) == 0, int'($urandom % 8),
            int'($urandom % 8), 1'b0, 0, "rnd");
    end
  endtask

  initial begin
    i_Reset_n = 1'b1;
    i_Phase = '0;
    i_NoteOn = 1'b0;
    i_VoiceOperator = '0;
    i_ModulationPhase = '0;
    i_FeedbackConfigWriteEnable = 1'b0;
    i_ConfigWriteAddr = '0;
    i_ConfigWriteData = '0;
    for (int i = 0; i < 8; i++) begin
      m_level[i] = 0;
      m_valid[i] = 1'b0;
      m_last[i]  = 0;
    end

    do_reset();
    cyc = 0;

    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 25,     "ph0000");
    drive(16'h4000, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 32767,  "ph4000");
    drive(16'h8000, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, -25,    "ph8000");
    drive(16'hC000, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, -32767, "phC000");
    drive(16'h3FF0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 32767,  "ph3FF0");
    drive(16'h7FF0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 25,     "ph7FF0");
    drive(16'hF000, 16'h2000, 1'b1, 1'b0, 0, 0, 1'b1, rom(256), "wrap");
    drive(16'h1000, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, rom(256), "ph1000");

    // Note-off clears history; level write lands in the same cycle as the read.
    pass_op2(16'h1234, 1'b0, 1'b1, 7, 1'b1, 0,  "off_op2");
    pass_op2(16'h0000, 1'b1, 1'b0, 0, 1'b1, 25, "fb_first");
    pass_op2(16'h0000, 1'b1, 1'b0, 0, 1'b1, 25, "fb_second");
    pass_op2(16'h4000, 1'b1, 1'b0, 0, 1'b1, 32767, "fb_4000a");
    pass_op2(16'h4000, 1'b1, 1'b0, 0, 1'b1, 25, "fb_4000b");
    for (int k = 0; k < 8; k++) pass_op2(16'(k * 16'h2000 + 16'h0150), 1'b1, 1'b0, 0, 1'b0, 0, "fb_sweep");

    random_run(400);

    do_reset();
    pass_op2(16'h4000, 1'b1, 1'b0, 0, 1'b1, 32767, "post_rst_a");
    pass_op2(16'h4000, 1'b1, 1'b0, 0, 1'b1, 32767, "post_rst_b");

    random_run(200);
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
